// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-number width, ALU operation codes and
// the bundle of EX-stage control bits used by pipeline registers.
package mips_pkg;

  localparam int REG_W = 5;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [3:0] aluop;
  } ctrl_t;

  // A bubble carries no side effects: nothing written, nothing loaded or stored.
  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID-to-EX bundle: decoded ID-stage fields in, registered EX-stage copies,
// stall and event counters out. Valid/ready: stall=1 means ID must re-present the same instruction next cycle.
interface id_ex_hazard_reg_if
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 16
) ();

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rw;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  logic             id_memtoreg;
  logic             id_alusrc;
  logic [3:0]       id_aluop;
  logic [DW-1:0]    id_busa;
  logic [DW-1:0]    id_busb;
  logic [DW-1:0]    id_imm;
  logic             flush;

  logic             stall;
  logic             ex_valid;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] ex_rw;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_memwrite;
  logic             ex_memtoreg;
  logic             ex_alusrc;
  logic [3:0]       ex_aluop;
  logic [DW-1:0]    ex_busa;
  logic [DW-1:0]    ex_busb;
  logic [DW-1:0]    ex_imm;
  logic [CW-1:0]    stall_cnt;
  logic [CW-1:0]    flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rw, id_uses_rs, id_uses_rt,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc,
           id_aluop, id_busa, id_busb, id_imm, flush,
    input  stall, ex_valid, ex_rs, ex_rt, ex_rw, ex_regwrite, ex_memread,
           ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop, ex_busa, ex_busb,
           ex_imm, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rw, id_uses_rs, id_uses_rt,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc,
           id_aluop, id_busa, id_busb, id_imm, flush,
    output stall, ex_valid, ex_rs, ex_rt, ex_rw, ex_regwrite, ex_memread,
           ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop, ex_busa, ex_busb,
           ex_imm, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Combinational load-use detector: a load in EX whose nonzero destination is
// read by the valid instruction in ID. A taken flush suppresses the stall.
module load_use_detect
  import mips_pkg::*;
(
  input  logic             i_ex_valid,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rw,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_flush,
  output logic             o_lu,
  output logic             o_stall
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_id_uses_rs && (i_ex_rw == i_id_rs);
  assign w_rt_hit = i_id_uses_rt && (i_ex_rw == i_id_rt);

  assign o_lu    = i_ex_valid && i_ex_memread && (i_ex_rw != '0) && i_id_valid
                   && (w_rs_hit || w_rt_hit);
  assign o_stall = o_lu && !i_flush;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion and saturating
// stall/flush event counters.
module id_ex_hazard_reg
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input logic               clk,
  input logic               rst,
  id_ex_hazard_reg_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic             w_lu;
  logic             w_stall;
  ctrl_t            w_id_ctrl;

  logic             r_valid;
  logic [REG_W-1:0] r_rs;
  logic [REG_W-1:0] r_rt;
  logic [REG_W-1:0] r_rw;
  ctrl_t            r_ctrl;
  logic [DW-1:0]    r_busa;
  logic [DW-1:0]    r_busb;
  logic [DW-1:0]    r_imm;
  logic [CW-1:0]    r_stall_cnt;
  logic [CW-1:0]    r_flush_cnt;

  load_use_detect u_lud (
    .i_ex_valid   (r_valid),
    .i_ex_memread (r_ctrl.memread),
    .i_ex_rw      (r_rw),
    .i_id_valid   (bus.id_valid),
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .i_id_uses_rs (bus.id_uses_rs),
    .i_id_uses_rt (bus.id_uses_rt),
    .i_flush      (bus.flush),
    .o_lu         (w_lu),
    .o_stall      (w_stall)
  );

  assign w_id_ctrl = '{regwrite: bus.id_regwrite, memread: bus.id_memread,
                       memwrite: bus.id_memwrite, memtoreg: bus.id_memtoreg,
                       alusrc: bus.id_alusrc, aluop: bus.id_aluop};

  // Bubbles also zero the register numbers so the forwarding unit never matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rw    <= '0;
      r_ctrl  <= CTRL_NOP;
      r_busa  <= '0;
      r_busb  <= '0;
      r_imm   <= '0;
    end else if (bus.flush || w_lu) begin
      r_valid <= 1'b0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rw    <= '0;
      r_ctrl  <= CTRL_NOP;
      r_busa  <= '0;
      r_busb  <= '0;
      r_imm   <= '0;
    end else begin
      r_valid <= bus.id_valid;
      r_rs    <= bus.id_rs;
      r_rt    <= bus.id_rt;
      r_rw    <= bus.id_rw;
      r_ctrl  <= gate_ctrl(w_id_ctrl, bus.id_valid);
      r_busa  <= bus.id_busa;
      r_busb  <= bus.id_busb;
      r_imm   <= bus.id_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.flush && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall       = w_stall;
  assign bus.ex_valid    = r_valid;
  assign bus.ex_rs       = r_rs;
  assign bus.ex_rt       = r_rt;
  assign bus.ex_rw       = r_rw;
  assign bus.ex_regwrite = r_ctrl.regwrite;
  assign bus.ex_memread  = r_ctrl.memread;
  assign bus.ex_memwrite = r_ctrl.memwrite;
  assign bus.ex_memtoreg = r_ctrl.memtoreg;
  assign bus.ex_alusrc   = r_ctrl.alusrc;
  assign bus.ex_aluop    = r_ctrl.aluop;
  assign bus.ex_busa     = r_busa;
  assign bus.ex_busb     = r_busb;
  assign bus.ex_imm      = r_imm;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed hazard scenarios plus random traffic,
// expected EX contents queued at drive time and compared after the edge.
module tb_id_ex_hazard_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rw;
    logic        uses_rs;
    logic        uses_rt;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] imm;
  } id_in_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rw;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] imm;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  id_ex_hazard_reg_if #(.DW(DW), .CW(CW)) bus ();

  id_ex_hazard_reg #(.DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int        n_cmp = 0;
  int        n_err = 0;
  ex_t       exp_q[$];
  ex_t       m_ex;
  logic [3:0] m_scnt;
  logic [3:0] m_fcnt;
  id_in_t    cur_id;
  logic      cur_fl;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic id_in_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rw, input logic urs, input logic urt,
                                input logic rwe, input logic mr, input logic mw,
                                input logic mtr, input logic as, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm);
    id_in_t r;
    r = '{valid: v, rs: rs, rt: rt, rw: rw, uses_rs: urs, uses_rt: urt, regwrite: rwe,
          memread: mr, memwrite: mw, memtoreg: mtr, alusrc: as, aluop: op,
          busa: a, busb: b, imm: imm};
    return r;
  endfunction

  function automatic id_in_t f_lw(input logic [4:0] base, input logic [4:0] rw);
    return mk(1'b1, base, rw, rw, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2,
              32'h1000, 32'h0, 32'h4);
  endfunction

  function automatic id_in_t f_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return mk(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2,
              32'h11, 32'h22, 32'h0);
  endfunction

  function automatic logic model_lu(input id_in_t id);
    return m_ex.valid && m_ex.memread && (m_ex.rw != 5'd0) && id.valid &&
           ((id.uses_rs && (m_ex.rw == id.rs)) || (id.uses_rt && (m_ex.rw == id.rt)));
  endfunction

  function automatic ex_t got_ex();
    ex_t g;
    g = '{valid: bus.ex_valid, rs: bus.ex_rs, rt: bus.ex_rt, rw: bus.ex_rw,
          regwrite: bus.ex_regwrite, memread: bus.ex_memread, memwrite: bus.ex_memwrite,
          memtoreg: bus.ex_memtoreg, alusrc: bus.ex_alusrc, aluop: bus.ex_aluop,
          busa: bus.ex_busa, busb: bus.ex_busb, imm: bus.ex_imm};
    return g;
  endfunction

  task automatic drive(input id_in_t id, input logic fl);
    bus.id_valid    = id.valid;
    bus.id_rs       = id.rs;
    bus.id_rt       = id.rt;
    bus.id_rw       = id.rw;
    bus.id_uses_rs  = id.uses_rs;
    bus.id_uses_rt  = id.uses_rt;
    bus.id_regwrite = id.regwrite;
    bus.id_memread  = id.memread;
    bus.id_memwrite = id.memwrite;
    bus.id_memtoreg = id.memtoreg;
    bus.id_alusrc   = id.alusrc;
    bus.id_aluop    = id.aluop;
    bus.id_busa     = id.busa;
    bus.id_busb     = id.busb;
    bus.id_imm      = id.imm;
    bus.flush       = fl;
    cur_id = id;
    cur_fl = fl;
  endtask

  task automatic present(input id_in_t id, input logic fl);
    @(negedge clk);
    drive(id, fl);
    #1;
    check("stall_model", bus.stall, model_lu(id) && !fl);
  endtask

  task automatic advance();
    ex_t nxt;
    ex_t exp;
    logic lu;
    lu  = model_lu(cur_id);
    nxt = '0;
    if (!cur_fl && !lu) begin
      nxt.valid = cur_id.valid;
      nxt.rs    = cur_id.rs;
      nxt.rt    = cur_id.rt;
      nxt.rw    = cur_id.rw;
      nxt.busa  = cur_id.busa;
      nxt.busb  = cur_id.busb;
      nxt.imm   = cur_id.imm;
      if (cur_id.valid) begin
        nxt.regwrite = cur_id.regwrite;
        nxt.memread  = cur_id.memread;
        nxt.memwrite = cur_id.memwrite;
        nxt.memtoreg = cur_id.memtoreg;
        nxt.alusrc   = cur_id.alusrc;
        nxt.aluop    = cur_id.aluop;
      end
    end
    if (lu && !cur_fl && m_scnt != 4'hF) m_scnt = m_scnt + 4'd1;
    if (cur_fl && m_fcnt != 4'hF) m_fcnt = m_fcnt + 4'd1;
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    m_ex = nxt;
    exp = exp_q.pop_front();
    check("ex_regs", got_ex(), exp);
    check("stall_cnt_model", bus.stall_cnt, m_scnt);
    check("flush_cnt_model", bus.flush_cnt, m_fcnt);
  endtask

  task automatic model_clear();
    m_ex = '0;
    m_scnt = '0;
    m_fcnt = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive('0, 1'b0);
    #1;
    check("rst_ex", got_ex(), '0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_scnt", bus.stall_cnt, 4'd0);
    check("rst_fcnt", bus.flush_cnt, 4'd0);
    model_clear();
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    id_in_t id;
    model_clear();
    drive('0, 1'b0);
    do_reset();

    // Plain pass-through, one-cycle latency
    present(mk(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2,
               32'hDEADBEEF, 32'h12345678, 32'h0000FFFC), 1'b0);
    advance();
    check("pt_busa", bus.ex_busa, 32'hDEADBEEF);
    check("pt_imm", bus.ex_imm, 32'h0000FFFC);
    check("pt_aluop", bus.ex_aluop, 4'h2);
    check("pt_rw", bus.ex_rw, 5'd9);
    check("pt_regwrite", bus.ex_regwrite, 1'b1);

    // Load-use on rs
    present(f_lw(5'd1, 5'd5), 1'b0);
    advance();
    present(f_rtype(5'd5, 5'd6, 5'd8), 1'b0);
    check("lu_stall", bus.stall, 1'b1);
    advance();
    check("lu_bubble_valid", bus.ex_valid, 1'b0);
    check("lu_bubble_regwrite", bus.ex_regwrite, 1'b0);
    check("lu_stall_cnt", bus.stall_cnt, 4'd1);
    present(f_rtype(5'd5, 5'd6, 5'd8), 1'b0);
    check("lu_replay_stall", bus.stall, 1'b0);
    advance();
    check("lu_replay_rs", bus.ex_rs, 5'd5);
    check("lu_replay_valid", bus.ex_valid, 1'b1);

    // Load to r0 never stalls
    present(f_lw(5'd1, 5'd0), 1'b0);
    advance();
    present(f_rtype(5'd0, 5'd0, 5'd8), 1'b0);
    check("r0_stall", bus.stall, 1'b0);
    advance();

    // Unused operand never stalls
    present(f_lw(5'd1, 5'd7), 1'b0);
    advance();
    present(mk(1'b1, 5'd1, 5'd7, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2,
               32'h5, 32'h6, 32'h7), 1'b0);
    check("unused_stall", bus.stall, 1'b0);
    advance();
    check("unused_rt", bus.ex_rt, 5'd7);
    check("unused_valid", bus.ex_valid, 1'b1);

    // Back-to-back loads
    present(f_lw(5'd1, 5'd2), 1'b0);
    advance();
    present(f_lw(5'd2, 5'd3), 1'b0);
    check("bb_stall1", bus.stall, 1'b1);
    advance();
    present(f_lw(5'd2, 5'd3), 1'b0);
    check("bb_replay", bus.stall, 1'b0);
    advance();
    present(f_rtype(5'd4, 5'd3, 5'd11), 1'b0);
    check("bb_stall2", bus.stall, 1'b1);
    advance();
    present(f_rtype(5'd4, 5'd3, 5'd11), 1'b0);
    advance();

    // Flush beats load-use
    do_reset();
    present(f_lw(5'd1, 5'd4), 1'b0);
    advance();
    present(f_rtype(5'd4, 5'd0, 5'd12), 1'b1);
    check("fl_stall", bus.stall, 1'b0);
    advance();
    check("fl_fcnt", bus.flush_cnt, 4'd1);
    check("fl_scnt", bus.stall_cnt, 4'd0);
    check("fl_valid", bus.ex_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      id = mk(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom, $urandom, $urandom);
      present(id, 1'($urandom_range(0, 7) == 0));
      advance();
    end

    // Asynchronous reset between edges
    present(f_lw(5'd1, 5'd6), 1'b0);
    advance();
    present(f_rtype(5'd6, 5'd1, 5'd13), 1'b0);
    advance();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", bus.ex_valid, 1'b0);
    check("arst_ex", got_ex(), '0);
    check("arst_scnt", bus.stall_cnt, 4'd0);
    check("arst_stall", bus.stall, 1'b0);
    model_clear();
    @(negedge clk);
    drive('0, 1'b0);
    #4;
    rst = 1'b0;

    // Flush counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      present('0, 1'b1);
      advance();
    end
    check("fl_sat", bus.flush_cnt, 4'd15);
    present('0, 1'b0);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded operands, register numbers and control bits from ID each cycle.
- Presents rs/rt and the destination register to the EX-stage forwarding unit. The EX-stage register number and RegWrite drive the forwarding unit's RW_EX/RegWrite_EX, and rs/rt drive its rs/rt.
- On a load-use dependency, holds PC and IF/ID via `stall` and injects a bubble into EX. Also counts stall and flush events for performance debug.

Parameters:
- DW, 32, datapath width of busA/busB/imm
- CW, 16, width of saturating stall/flush event counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  source register A number
- id_rt  in  5  source register B number
- id_rw  in  5  destination register number (already muxed rt/rd/31)
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt (R-type, store, beq/bne)
- id_regwrite  in  1  RegWrite control
- id_memread  in  1  load
- id_memwrite  in  1  store
- id_memtoreg  in  1  MemtoReg control
- id_alusrc  in  1  ALU B from immediate
- id_aluop  in  4  ALU operation
- id_busa  in  DW  register file read A
- id_busb  in  DW  register file read B
- id_imm  in  DW  extended immediate
- flush  in  1  branch/jump resolved taken in EX; kill the ID instruction
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid, ex_rs, ex_rt, ex_rw, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop, ex_busa, ex_busb, ex_imm  out  matching widths  registered EX-stage copies
- stall_cnt  out  CW  saturating count of stall cycles
- flush_cnt  out  CW  saturating count of flush cycles

Behaviour:
- Reset: clock and reset are one clock, asynchronous active-high reset (clk, rst).
  - All ex_* outputs are 0, including ex_valid=0.
  - Both counters are 0.
  - stall is 0, because it is derived from ex_valid=0.
- Hazard condition (combinational):
  - `lu = ex_valid & ex_memread & (ex_rw!=0) & id_valid & ((id_uses_rs & ex_rw==id_rs) | (id_uses_rt & ex_rw==id_rt))`.
  - `stall = lu & !flush`.
- Each rising edge, priority order:
  1. flush=1: load a bubble. ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg all go to 0. ex_rs/ex_rt/ex_rw also go to 0 so forwarding never matches. Data fields are don't-care, driven 0.
  2. else lu=1: load the same bubble. The ID instruction is retained upstream by stall and re-presented next cycle.
  3. else: capture all id_* into ex_*. ex_valid=id_valid. If id_valid=0, control bits are gated to 0.
- Latency: 1 cycle from ID input to ex_* output. Stall lasts exactly 1 cycle per load-use, because the bubble clears ex_memread.
- Back-to-back loads, e.g. lw r2 then lw r3 using r2: one stall. The second load then enters EX normally and may stall its own consumer.
- A load writing r0 never stalls.
- A dependency via an operand the instruction does not use (id_uses_*=0) never stalls.
- flush and lu in the same cycle: flush wins, stall=0, flush_cnt increments, stall_cnt does not.
- Counters: stall_cnt += 1 on each edge where stall=1; flush_cnt += 1 on each edge where flush=1. Both saturate at 2^CW-1, no wrap.
- Reset asserted mid-operation clears all state immediately, independent of clk. stall drops as soon as ex_valid clears.

Decomposition:
- Shared package `mips_pkg` holds:
  - ALUOP encoding constants (4-bit)
  - the register-number width constant (5)
  - the bubble/NOP control vector constant
- One natural sub-module: `load_use_detect` (pure combinational lu/stall logic). It is reusable by a future branch-in-ID hazard unit.
- Register bank and counters stay in the top module.

Test Plan:
- Reset mid-run: drive a valid instruction, assert rst asynchronously between edges -> all ex_* read 0 and stall_cnt=0 immediately, before the next clk edge.
- Load-use on rs: EX holds lw with ex_rw=5; ID holds add rs=5, rt=6, uses_rs=1, uses_rt=1 -> stall=1. Next edge ex_valid=0 and ex_regwrite=0, stall_cnt=1. Following edge the add appears in EX with ex_rs=5.
- Non-hazard cases:
  - lw r0 followed by an instruction reading r0 -> stall=0.
  - lw r7 followed by addi with rt=7 and uses_rt=0 -> stall=0; the addi passes through in 1 cycle.
- Flush priority: lu condition true and flush=1 on the same edge -> stall=0, bubble loaded, flush_cnt=1, stall_cnt=0.
- Plain pass-through: id_busa=32'hDEADBEEF, id_imm=32'h0000FFFC, aluop=4'h2, regwrite=1, rw=9 -> identical values on ex_* after exactly 1 edge.
- Saturation: with CW=4, force 20 consecutive flush cycles -> flush_cnt stops at 15.
